memory_stage: RTL and testbench

//  Pipeline MEM stage. Sits directly after the execute stage and ahead of writeback.

---
 rtl/memory_stage.sv | 98 +++++++++
 tb/tb_memory_stage.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_stage.sv
// memory_stage: pipeline MEM stage running loads/stores on a valid/ready data port, with WB and MEM->EX forwarding
module memory_stage #(
  parameter int XLEN = 64,
  parameter int REG_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             EXMEM_ready,
  input  logic [XLEN-1:0]  exmm_aluresult,
  input  logic [XLEN-1:0]  EXMEM_rs2,
  input  logic [REG_W-1:0] dest_reg,
  input  logic             mem_active,
  input  logic             load,
  input  logic [1:0]       mem_size,
  input  logic             mem_unsigned,
  input  logic             EXMEM_wbactive,
  output logic             dreq_valid,
  input  logic             dreq_ready,
  output logic [XLEN-1:0]  dreq_addr,
  output logic             dreq_we,
  output logic [XLEN-1:0]  dreq_wdata,
  output logic [7:0]       dreq_wstrb,
  input  logic             dresp_valid,
  input  logic [XLEN-1:0]  dresp_data,
  output logic             MEMEX_stall,
  output logic [REG_W-1:0] MEMEX_rd,
  output logic [XLEN-1:0]  MEMEX_rdval,
  output logic             MEMEX_wbactive,
  output logic             MEMWB_ready,
  output logic [REG_W-1:0] MEMWB_rd,
  output logic [XLEN-1:0]  MEMWB_rdval,
  output logic             MEMWB_wbactive,
  output logic             mem_misalign
);
  localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, DONE = 2'd3;
  logic [1:0] state, nxt, sz;
  logic v, mem, ld, uns, wb, fresh, cap, mis, req, ret;
  logic [XLEN-1:0] alu, rs2, res, lane, ext;
  logic [REG_W-1:0] rd;
  logic [2:0] mask, a;
  logic [7:0] strb;
  assign req = state == REQ;
  assign MEMEX_stall = req || state == WAIT;
  assign cap = EXMEM_ready && !MEMEX_stall;
  // misaligned accesses drop the low offset bits to the access size and go out once
  always_comb begin
    mask = sz == 2'd0 ? 3'd0 : sz == 2'd1 ? 3'd1 : sz == 2'd2 ? 3'd3 : 3'd7;
    a = alu[2:0] & ~mask;
    mis = mem && |(alu[2:0] & mask);
    strb = sz == 2'd3 ? 8'hFF : (sz == 2'd2 ? 8'h0F : sz == 2'd1 ? 8'h03 : 8'h01) << a;
    lane = dresp_data >> {a, 3'b000};
    ext = sz == 2'd0 ? {{(XLEN-8){!uns & lane[7]}}, lane[7:0]} :
          sz == 2'd1 ? {{(XLEN-16){!uns & lane[15]}}, lane[15:0]} :
          sz == 2'd2 ? {{(XLEN-32){!uns & lane[31]}}, lane[31:0]} : lane;
    ret = (v && !mem && fresh) || state == DONE;
    nxt = cap ? (mem_active ? REQ : IDLE) :
          req ? (dreq_ready ? WAIT : REQ) :
          state == WAIT ? (dresp_valid ? DONE : WAIT) : IDLE;
  end
  assign dreq_valid = req;
  assign dreq_addr = req ? {alu[XLEN-1:3], 3'b000} : '0;
  assign dreq_we = req && !ld;
  assign dreq_wstrb = req ? strb : '0;
  assign dreq_wdata = req ? rs2 << {a, 3'b000} : '0;
  assign MEMEX_rd = rd;
  assign MEMEX_rdval = mem ? res : alu;
  assign MEMEX_wbactive = v && wb && |rd && (!mem || (ld && state == DONE));
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      {v, mem, ld, uns, wb, fresh, sz, rd} <= '0;
      {alu, rs2, res} <= '0;
      {MEMWB_ready, MEMWB_rd, MEMWB_rdval, MEMWB_wbactive, mem_misalign} <= '0;
    end else begin
      state <= nxt;
      fresh <= cap;
      if (cap) begin
        v <= 1'b1;
        alu <= exmm_aluresult;
        rs2 <= EXMEM_rs2;
        rd <= dest_reg;
        mem <= mem_active;
        ld <= load;
        sz <= mem_size;
        uns <= mem_unsigned;
        wb <= EXMEM_wbactive;
      end
      if (state == WAIT && dresp_valid) res <= ext;
      MEMWB_ready <= ret;
      MEMWB_wbactive <= ret && wb && |rd && (!mem || ld);
      mem_misalign <= ret && mis;
      if (ret) begin
        MEMWB_rd <= rd;
        MEMWB_rdval <= mem ? res : alu;
      end
    end
  end
endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: table vectors, randomized ops against an arithmetic reference, and multi-cycle corner sequences
module tb_memory_stage;
  logic clk, reset, EXMEM_ready, mem_active, load, mem_unsigned, EXMEM_wbactive;
  logic [63:0] exmm_aluresult, EXMEM_rs2, dreq_addr, dreq_wdata, dresp_data, MEMEX_rdval, MEMWB_rdval;
  logic [5:0] dest_reg, MEMEX_rd, MEMWB_rd;
  logic [1:0] mem_size;
  logic dreq_valid, dreq_ready, dreq_we, dresp_valid, MEMEX_stall, MEMEX_wbactive;
  logic MEMWB_ready, MEMWB_wbactive, mem_misalign;
  logic [7:0] dreq_wstrb;
  int n_chk = 0, n_fail = 0;

  typedef struct {
    logic [63:0] alu, rs2, rdata;
    logic [5:0] rd;
    logic mem, ld, uns, wb;
    logic [1:0] sz;
    int rdly, pdly;
    logic [63:0] e_addr, e_wdata, e_rdval;
    logic [7:0] e_strb;
    logic e_mis, e_wb;
  } vec_t;

  vec_t tbl[11];

  memory_stage dut (
    .clk(clk), .reset(reset), .EXMEM_ready(EXMEM_ready), .exmm_aluresult(exmm_aluresult),
    .EXMEM_rs2(EXMEM_rs2), .dest_reg(dest_reg), .mem_active(mem_active), .load(load),
    .mem_size(mem_size), .mem_unsigned(mem_unsigned), .EXMEM_wbactive(EXMEM_wbactive),
    .dreq_valid(dreq_valid), .dreq_ready(dreq_ready), .dreq_addr(dreq_addr), .dreq_we(dreq_we),
    .dreq_wdata(dreq_wdata), .dreq_wstrb(dreq_wstrb), .dresp_valid(dresp_valid),
    .dresp_data(dresp_data), .MEMEX_stall(MEMEX_stall), .MEMEX_rd(MEMEX_rd),
    .MEMEX_rdval(MEMEX_rdval), .MEMEX_wbactive(MEMEX_wbactive), .MEMWB_ready(MEMWB_ready),
    .MEMWB_rd(MEMWB_rd), .MEMWB_rdval(MEMWB_rdval), .MEMWB_wbactive(MEMWB_wbactive),
    .mem_misalign(mem_misalign)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // reference: byte arithmetic on offsets and sizes, no bit-level mirroring of the design
  function automatic vec_t model(input logic [63:0] alu, rs2, rdata, input logic [5:0] rd,
                                 input logic mem, ld, uns, wb, input logic [1:0] sz);
    vec_t t;
    int n, off, ao;
    logic [63:0] val, lim;
    t.alu = alu; t.rs2 = rs2; t.rdata = rdata; t.rd = rd; t.mem = mem; t.ld = ld;
    t.uns = uns; t.wb = wb; t.sz = sz;
    t.rdly = $urandom_range(0, 3); t.pdly = $urandom_range(0, 3);
    n = 1 << sz;
    off = int'(alu % 64'd8);
    ao = off - off % n;
    t.e_addr = alu - 64'(off);
    t.e_strb = (n == 8) ? 8'hFF : 8'(((1 << n) - 1) << ao);
    t.e_wdata = rs2 << (ao * 8);
    t.e_mis = mem && (off % n != 0);
    val = rdata >> (ao * 8);
    if (n < 8) begin
      lim = 64'd1 << (8 * n);
      val = val % lim;
      if (!uns && val >= (lim >> 1)) val = val - lim;
    end
    t.e_rdval = mem ? val : alu;
    t.e_wb = wb && rd != 0 && (!mem || ld);
    return t;
  endfunction

  task automatic drive(input vec_t t);
    EXMEM_ready = 1; exmm_aluresult = t.alu; EXMEM_rs2 = t.rs2; dest_reg = t.rd;
    mem_active = t.mem; load = t.ld; mem_size = t.sz; mem_unsigned = t.uns; EXMEM_wbactive = t.wb;
  endtask

  task automatic do_op(input vec_t t);
    @(negedge clk);
    drive(t);
    @(negedge clk);
    EXMEM_ready = 0;
    if (!t.mem) begin
      chk("nm_stall", MEMEX_stall, 0);
      chk("nm_dreq_valid", dreq_valid, 0);
      chk("nm_fwd_val", MEMEX_rdval, t.alu);
      chk("nm_fwd_wb", MEMEX_wbactive, t.e_wb);
      chk("nm_early_retire", MEMWB_ready, 0);
      @(negedge clk);
    end else begin
      for (int i = 0; i <= t.rdly; i++) begin
        chk("req_valid", dreq_valid, 1);
        chk("req_stall", MEMEX_stall, 1);
        chk("req_addr", dreq_addr, t.e_addr);
        chk("req_we", dreq_we, !t.ld);
        chk("req_wstrb", dreq_wstrb, t.e_strb);
        if (!t.ld) chk("req_wdata", dreq_wdata, t.e_wdata);
        if (i == t.rdly) dreq_ready = 1;
        @(negedge clk);
      end
      dreq_ready = 0;
      for (int i = 0; i <= t.pdly; i++) begin
        chk("wait_valid", dreq_valid, 0);
        chk("wait_stall", MEMEX_stall, 1);
        if (i == t.pdly) begin dresp_valid = 1; dresp_data = t.rdata; end
        @(negedge clk);
      end
      dresp_valid = 0;
      chk("done_stall", MEMEX_stall, 0);
      chk("done_fwd_wb", MEMEX_wbactive, t.e_wb);
      if (t.ld) chk("done_fwd_val", MEMEX_rdval, t.e_rdval);
      chk("done_early_retire", MEMWB_ready, 0);
      @(negedge clk);
    end
    chk("retire_ready", MEMWB_ready, 1);
    chk("retire_rd", MEMWB_rd, t.rd);
    chk("retire_wbactive", MEMWB_wbactive, t.e_wb);
    chk("retire_misalign", mem_misalign, t.e_mis);
    if (!t.mem || t.ld) chk("retire_rdval", MEMWB_rdval, t.e_rdval);
    @(negedge clk);
    chk("retire_pulse", MEMWB_ready, 0);
  endtask

  initial begin
    vec_t t;
    reset = 0; EXMEM_ready = 0; exmm_aluresult = 0; EXMEM_rs2 = 0; dest_reg = 0; mem_active = 0;
    load = 0; mem_size = 0; mem_unsigned = 0; EXMEM_wbactive = 0; dreq_ready = 0;
    dresp_valid = 0; dresp_data = 0;
    tbl[0]  = '{64'h1234, 64'h0, 64'h0, 6'd5, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 0, 0,
                64'h0, 64'h0, 64'h1234, 8'h00, 1'b0, 1'b1};
    tbl[1]  = '{64'h1003, 64'h0, 64'h80000000, 6'd3, 1'b1, 1'b1, 1'b0, 1'b1, 2'd0, 0, 0,
                64'h1000, 64'h0, 64'hFFFFFFFFFFFFFF80, 8'h08, 1'b0, 1'b1};
    tbl[2]  = '{64'h1003, 64'h0, 64'h80000000, 6'd4, 1'b1, 1'b1, 1'b1, 1'b1, 2'd0, 0, 0,
                64'h1000, 64'h0, 64'h80, 8'h08, 1'b0, 1'b1};
    tbl[3]  = '{64'h2006, 64'hBEEF, 64'h0, 6'd10, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 3, 0,
                64'h2000, 64'hBEEF000000000000, 64'h0, 8'hC0, 1'b0, 1'b0};
    tbl[4]  = '{64'h3002, 64'h0, 64'h1122334455667788, 6'd8, 1'b1, 1'b1, 1'b0, 1'b1, 2'd2, 0, 1,
                64'h3000, 64'h0, 64'h55667788, 8'h0F, 1'b1, 1'b1};
    tbl[5]  = '{64'h4008, 64'h0, 64'h8000000000000001, 6'd0, 1'b1, 1'b1, 1'b0, 1'b1, 2'd3, 1, 0,
                64'h4008, 64'h0, 64'h8000000000000001, 8'hFF, 1'b0, 1'b0};
    tbl[6]  = '{64'h5002, 64'h0, 64'h80010000, 6'd9, 1'b1, 1'b1, 1'b0, 1'b1, 2'd1, 0, 2,
                64'h5000, 64'h0, 64'hFFFFFFFFFFFF8001, 8'h0C, 1'b0, 1'b1};
    tbl[7]  = '{64'h6004, 64'h0, 64'hF000000000000000, 6'd11, 1'b1, 1'b1, 1'b1, 1'b1, 2'd2, 2, 2,
                64'h6000, 64'h0, 64'hF0000000, 8'hF0, 1'b0, 1'b1};
    tbl[8]  = '{64'h7008, 64'h0123456789ABCDEF, 64'h0, 6'd12, 1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 0, 0,
                64'h7008, 64'h0123456789ABCDEF, 64'h0, 8'hFF, 1'b0, 1'b0};
    tbl[9]  = '{64'h8000, 64'h0, 64'hFFFFFFFFFFFFFFFE, 6'd13, 1'b1, 1'b1, 1'b1, 1'b1, 2'd3, 0, 0,
                64'h8000, 64'h0, 64'hFFFFFFFFFFFFFFFE, 8'hFF, 1'b0, 1'b1};
    tbl[10] = '{64'h9007, 64'hAABBCCDD, 64'h0, 6'd14, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 1, 1,
                64'h9000, 64'hAABBCCDD00000000, 64'h0, 8'hF0, 1'b1, 1'b0};

    repeat (2) @(negedge clk);
    chk("rst_stall", MEMEX_stall, 0);
    chk("rst_dreq_valid", dreq_valid, 0);
    chk("rst_dreq_addr", dreq_addr, 0);
    chk("rst_dreq_wstrb", dreq_wstrb, 0);
    chk("rst_memex_rd", MEMEX_rd, 0);
    chk("rst_memex_rdval", MEMEX_rdval, 0);
    chk("rst_memex_wb", MEMEX_wbactive, 0);
    chk("rst_memwb_ready", MEMWB_ready, 0);
    chk("rst_memwb_rdval", MEMWB_rdval, 0);
    chk("rst_misalign", mem_misalign, 0);
    reset = 1;

    foreach (tbl[i]) do_op(tbl[i]);

    for (int i = 0; i < 40; i++)
      do_op(model({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                  6'($urandom_range(0, 63)), $urandom_range(0, 2) != 0, 1'($urandom),
                  1'($urandom), 1'($urandom), 2'($urandom)));

    // ld rd=7 followed by addi held in EX
    @(negedge clk);
    t = model(64'h100, 0, 0, 6'd7, 1, 1, 0, 1, 2'd3);
    drive(t);
    @(negedge clk);
    t = model(64'h55, 0, 0, 6'd8, 0, 0, 0, 1, 2'd0);
    drive(t);
    chk("b2b_req_stall", MEMEX_stall, 1);
    dreq_ready = 1;
    @(negedge clk);
    dreq_ready = 0;
    chk("b2b_wait_stall", MEMEX_stall, 1);
    chk("b2b_held_rd", MEMEX_rd, 7);
    chk("b2b_wait_fwd", MEMEX_wbactive, 0);
    dresp_valid = 1; dresp_data = 64'hCAFEF00DDEADBEEF;
    @(negedge clk);
    dresp_valid = 0;
    chk("b2b_done_stall", MEMEX_stall, 0);
    chk("b2b_done_fwd_wb", MEMEX_wbactive, 1);
    chk("b2b_done_fwd_val", MEMEX_rdval, 64'hCAFEF00DDEADBEEF);
    @(negedge clk);
    EXMEM_ready = 0;
    chk("b2b_ld_ready", MEMWB_ready, 1);
    chk("b2b_ld_rd", MEMWB_rd, 7);
    chk("b2b_ld_val", MEMWB_rdval, 64'hCAFEF00DDEADBEEF);
    @(negedge clk);
    chk("b2b_addi_ready", MEMWB_ready, 1);
    chk("b2b_addi_rd", MEMWB_rd, 8);
    chk("b2b_addi_val", MEMWB_rdval, 64'h55);
    @(negedge clk);
    chk("b2b_pulse", MEMWB_ready, 0);

    // reset while waiting for the response
    t = model(64'h3000, 0, 0, 6'd6, 1, 1, 0, 1, 2'd2);
    drive(t);
    @(negedge clk);
    EXMEM_ready = 0; dreq_ready = 1;
    @(negedge clk);
    dreq_ready = 0;
    chk("rw_wait_stall", MEMEX_stall, 1);
    reset = 0;
    @(negedge clk);
    reset = 1; dresp_valid = 1; dresp_data = 64'h1234;
    chk("rw_stall", MEMEX_stall, 0);
    chk("rw_dreq_valid", dreq_valid, 0);
    chk("rw_memex_rd", MEMEX_rd, 0);
    chk("rw_memwb_ready", MEMWB_ready, 0);
    @(negedge clk);
    dresp_valid = 0;
    chk("rw_ignored_stall", MEMEX_stall, 0);
    chk("rw_ignored_retire", MEMWB_ready, 0);
    chk("rw_ignored_fwd", MEMEX_wbactive, 0);
    @(negedge clk);
    chk("rw_no_retire", MEMWB_ready, 0);

    // response coinciding with the request handshake must be dropped
    t = model(64'h200, 0, 0, 6'd9, 1, 1, 0, 1, 2'd3);
    drive(t);
    @(negedge clk);
    EXMEM_ready = 0; dreq_ready = 1; dresp_valid = 1; dresp_data = 64'h1111;
    @(negedge clk);
    dreq_ready = 0; dresp_valid = 0;
    chk("same_cyc_stall", MEMEX_stall, 1);
    chk("same_cyc_dreq", dreq_valid, 0);
    dresp_valid = 1; dresp_data = 64'h2222;
    @(negedge clk);
    dresp_valid = 0;
    chk("same_cyc_fwd", MEMEX_rdval, 64'h2222);
    @(negedge clk);
    chk("same_cyc_ready", MEMWB_ready, 1);
    chk("same_cyc_val", MEMWB_rdval, 64'h2222);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
